switch_input_port: RTL

- Memory-mapped input peripheral: the read side of the peripheral bus that carries switch state into the processor, complementing the LED output path.
- Synchronises and debounces the board switches per bit, latches change events in sticky flags, and raises a maskable interrupt.
- Sits on the data-memory bus beside the LED port; the top-level read mux selects ReadData when the address falls in this block's window.

---
 rtl/switch_input_port_if.sv | 9 +
 rtl/switch_input_port.sv | 50 +++++
 2 files changed

// File: rtl/switch_input_port_if.sv
// switch_input_port_if: data-memory bus slice seen by the switch input port
interface switch_input_port_if;
  logic [31:0] Adr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        MemWrite;
  modport master (output Adr, WriteData, MemWrite, input ReadData);
  modport slave (input Adr, WriteData, MemWrite, output ReadData);
endinterface

// File: rtl/switch_input_port.sv
// switch_input_port: synchronised, debounced switch register block with sticky change flags and maskable irq
module switch_input_port #(
  parameter int          N               = 10,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0800,
  parameter int          DEBOUNCE_CYCLES = 50000
) (
  input  logic                clk,
  input  logic                reset,
  switch_input_port_if.slave  bus,
  input  logic [N-1:0]        switches,
  output logic                irq
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [N-1:0] sync1, sync2, stable, edges, irq_en, done, clr;
  logic [CW-1:0] cnt [N];
  logic sel, we, unused_bits;
  logic [1:0] off;
  assign sel = bus.Adr[31:4] == BASE_ADDR[31:4];
  assign off = bus.Adr[3:2];
  assign we = bus.MemWrite & sel;
  assign clr = (we && off == 2'd1) ? bus.WriteData[N-1:0] : '0;
  assign unused_bits = ^{bus.Adr[1:0], bus.WriteData};
  for (genvar i = 0; i < N; i++) begin : g_bit
    assign done[i] = sync2[i] != stable[i] && cnt[i] == CW'(DEBOUNCE_CYCLES - 1);
    always_ff @(posedge clk or posedge reset)
      if (reset) cnt[i] <= '0;
      else cnt[i] <= (sync2[i] == stable[i] || done[i]) ? '0 : cnt[i] + 1'b1;
  end
  // a newly accepted level sets its flag even when the same edge clears it
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      edges  <= '0;
      irq_en <= '0;
    end else begin
      sync1  <= switches;
      sync2  <= sync1;
      stable <= stable ^ done;
      edges  <= (edges & ~clr) | done;
      if (we && off == 2'd2) irq_en <= bus.WriteData[N-1:0];
    end
  always_comb
    bus.ReadData = !sel       ? 32'd0 :
                   off == 2'd0 ? 32'(stable) :
                   off == 2'd1 ? 32'(edges) :
                   off == 2'd2 ? 32'(irq_en) : 32'(sync2);
  assign irq = |(edges & irq_en);
endmodule
